// File: rtl/mcc_pkg.sv
// mcc_pkg: constants and types shared by the MCC block-load path and the mcc controller
package mcc_pkg;
    localparam int XBAR_SIZE      = 32;
    localparam int XBAR_DIM_WIDTH = 5;
    localparam int DATA_WIDTH     = 8;
    typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;
    typedef logic [DATA_WIDTH-1:0] lane_t;
endpackage

// File: rtl/mcc_lane_mux.sv
// mcc_lane_mux: selects one DATA_WIDTH lane of a packed crossbar diagonal by offset
module mcc_lane_mux
    import mcc_pkg::*;
(
    input  logic [XBAR_SIZE*DATA_WIDTH-1:0] lanes_in,
    input  logic [XBAR_DIM_WIDTH-1:0]       sel_in,
    output lane_t                           lane_out
);
    assign lane_out = lanes_in[sel_in*DATA_WIDTH +: DATA_WIDTH];
endmodule

// File: rtl/mcc_block_tx.sv
// mcc_block_tx: serialises whole crossbar diagonals into the per-element mcc beat stream
module mcc_block_tx
    import mcc_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [XBAR_SIZE*DATA_WIDTH-1:0] diag_data_in,
    input  logic [XBAR_DIM_WIDTH-1:0]       diag_idx_in,
    input  logic                            diag_last_in,
    input  logic                            diag_valid_in,
    output logic                            diag_ready_out,
    input  logic                            abort_in,
    input  logic                            tx_ready_in,
    output logic [DATA_WIDTH-1:0]           b_value_out,
    output logic [XBAR_DIM_WIDTH-1:0]       b_diag_out,
    output logic [XBAR_DIM_WIDTH-1:0]       b_offset_out,
    output logic                            block_valid_out,
    output logic                            new_diagonal_out,
    output logic                            block_done_out
);
    tx_state_t                       state_q, state_d;
    logic [XBAR_DIM_WIDTH-1:0]       offset_q, offset_d;
    logic [XBAR_DIM_WIDTH-1:0]       idx_q, idx_d;
    logic [XBAR_SIZE*DATA_WIDTH-1:0] data_q, data_d;
    logic                            last_q, last_d;
    logic                            send, final_beat, accept;
    lane_t                           lane;

    mcc_lane_mux u_lane_mux (
        .lanes_in (data_q),
        .sel_in   (offset_q),
        .lane_out (lane)
    );

    assign send       = state_q == SEND;
    assign final_beat = send && tx_ready_in && offset_q == XBAR_DIM_WIDTH'(XBAR_SIZE - 1);
    // Ready opens on the final beat of a non-last diagonal so the next one follows with no bubble.
    assign diag_ready_out = state_q == IDLE || (final_beat && !last_q);
    assign accept         = diag_valid_in && diag_ready_out && !abort_in;

    always_comb begin
        state_d  = state_q;
        offset_d = (send && tx_ready_in) ? offset_q + XBAR_DIM_WIDTH'(1) : offset_q;
        idx_d    = accept ? diag_idx_in : idx_q;
        data_d   = accept ? diag_data_in : data_q;
        last_d   = accept ? diag_last_in : last_q;
        case (state_q)
            IDLE:    state_d = accept ? SEND : IDLE;
            SEND:    state_d = !final_beat ? SEND : last_q ? DONE : accept ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept || abort_in) offset_d = '0;
        if (abort_in) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            offset_q <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

    assign block_valid_out  = send;
    assign b_value_out      = send ? lane : '0;
    assign b_diag_out       = send ? idx_q : '0;
    assign b_offset_out     = send ? offset_q : '0;
    assign new_diagonal_out = send && offset_q == '0;
    assign block_done_out   = state_q == DONE;
endmodule
